// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: AES SubBytes/InvSubBytes over LANES composite-field S-box lanes, BEATS=16/LANES cycles per block.
// Optional define SUB_BYTES_PIPE_EN registers each lane after its GF(2^4) inverter (latency BEATS+1).
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int BEATS = 16 / LANES;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r, t;
    r = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_mul(a, a);
    a4 = gf4_mul(a2, a2);
    a8 = gf4_mul(a4, a4);
    return gf4_mul(gf4_mul(a2, a4), a8);
  endfunction

  // Smallest lambda making y^2+y+lambda irreducible over GF(2^4)
  function automatic logic [3:0] find_lambda();
    logic [3:0] r;
    logic ok;
    r = '0;
    for (int l = 15; l > 0; l--) begin
      ok = 1'b1;
      for (int g = 0; g < 16; g++)
        if ((gf4_mul(4'(g), 4'(g)) ^ 4'(g)) == 4'(l)) ok = 1'b0;
      if (ok) r = 4'(l);
    end
    return r;
  endfunction

  localparam logic [3:0] L = find_lambda();

  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf4_mul(a[7:4], b[7:4]);
    return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
            gf4_mul(hh, L) ^ gf4_mul(a[3:0], b[3:0])};
  endfunction

  function automatic logic [7:0] mat_mul(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (x[i]) r = r ^ m[8*i +: 8];
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Isomorphism columns are powers of a composite-field root of x^8+x^4+x^3+x+1
  function automatic logic [63:0] find_iso();
    logic [8:0][7:0] p;
    logic [63:0] m;
    logic found;
    m = '0;
    found = 1'b0;
    for (int b = 2; b < 256; b++) begin
      p[0] = 8'h01;
      for (int k = 1; k < 9; k++) p[k] = gf8_mul(p[k-1], 8'(b));
      if (!found && (p[8] ^ p[4] ^ p[3] ^ p[1] ^ p[0]) == 8'h00) begin
        found = 1'b1;
        for (int k = 0; k < 8; k++) m[8*k +: 8] = p[k];
      end
    end
    return m;
  endfunction

  function automatic logic [63:0] inv_mat(input logic [63:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int a = 0; a < 256; a++)
        if (mat_mul(m, 8'(a)) == 8'(1 << i)) r[8*i +: 8] = 8'(a);
    return r;
  endfunction

  function automatic logic [63:0] enc_mat(input logic [63:0] mi);
    logic [63:0] r;
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      v = mat_mul(mi, 8'(1 << i));
      r[8*i +: 8] = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4);
    end
    return r;
  endfunction

  function automatic logic [63:0] dec_mat(input logic [63:0] m);
    logic [63:0] r;
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      e = 8'(1 << i);
      r[8*i +: 8] = mat_mul(m, rotl(e, 1) ^ rotl(e, 3) ^ rotl(e, 6));
    end
    return r;
  endfunction

  localparam logic [63:0] M  = find_iso();
  localparam logic [63:0] MI = inv_mat(M);
  localparam logic [63:0] E  = enc_mat(MI);
  localparam logic [63:0] D  = dec_mat(M);
  localparam logic [7:0]  C5 = mat_mul(M, 8'h05);

  logic [1:0]    r_state;
  logic [CW-1:0] r_beat;
  logic [127:0]  r_src, r_res;
  logic          r_dec;
  logic [11:0]   w_a [LANES];
  logic [11:0]   w_b [LANES];
  logic [7:0]    w_out [LANES];
  logic [CW-1:0] w_wbeat;
  logic          w_wr;
  logic [CW-1:0] w_next;

  assign w_next = (BEATS == 1) ? '0 : r_beat + 1'b1;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0] w_x, w_v, w_inv;
    logic [3:0] w_d;
    assign w_x = r_src[(int'(r_beat) * LANES + j) * 8 +: 8];
    assign w_v = r_dec ? mat_mul(D, w_x) ^ C5 : mat_mul(M, w_x);
    assign w_d = gf4_mul(gf4_mul(w_v[7:4], w_v[7:4]), L) ^ gf4_mul(w_v[7:4], w_v[3:0]) ^ gf4_mul(w_v[3:0], w_v[3:0]);
    assign w_a[j] = {w_v, gf4_inv(w_d)};
    assign w_inv = {gf4_mul(w_b[j][11:8], w_b[j][3:0]), gf4_mul(w_b[j][11:8] ^ w_b[j][7:4], w_b[j][3:0])};
    assign w_out[j] = r_dec ? mat_mul(MI, w_inv) : mat_mul(E, w_inv) ^ 8'h63;
  end

`ifdef SUB_BYTES_PIPE_EN
  logic [11:0]   r_p [LANES];
  logic [CW-1:0] r_pbeat;
  logic          r_pvld, r_drain;
  assign w_b = r_p;
  assign w_wbeat = r_pbeat;
  assign w_wr = r_pvld;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_p <= '{default: '0};
      r_pbeat <= '0;
      r_pvld <= 1'b0;
    end else begin
      r_p <= w_a;
      r_pbeat <= r_beat;
      r_pvld <= r_state == BUSY && !r_drain;
    end
`else
  assign w_b = w_a;
  assign w_wbeat = r_beat;
  assign w_wr = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_beat <= '0;
      r_src <= '0;
      r_res <= '0;
      r_dec <= 1'b0;
`ifdef SUB_BYTES_PIPE_EN
      r_drain <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_src <= in_data;
          r_dec <= in_dec;
          r_beat <= '0;
          r_state <= BUSY;
        end
        BUSY: begin
          if (w_wr)
            for (int k = 0; k < LANES; k++) r_res[(int'(w_wbeat) * LANES + k) * 8 +: 8] <= w_out[k];
`ifdef SUB_BYTES_PIPE_EN
          if (!r_drain) begin
            r_beat <= w_next;
            r_drain <= r_beat == CW'(BEATS - 1);
          end else begin
            r_drain <= 1'b0;
            r_state <= DONE;
          end
`else
          r_beat <= w_next;
          if (r_beat == CW'(BEATS - 1)) r_state <= DONE;
`endif
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end

  assign in_ready  = r_state == IDLE;
  assign busy      = r_state != IDLE;
  assign out_valid = r_state == DONE;
  assign out_data  = r_res;
endmodule
